// File: rtl/ascon_fifo_if.sv
// Handshake/data bundle between an ascon_fifo and its producer/consumer.
// The slave modport is the FIFO side; the master modport is the bus or core side.
interface ascon_fifo_if #(
  parameter int WIDTH    = 64,
  parameter int DEPTH_AW = 4
);
  logic                flush_i;
  logic                push_i;
  logic [WIDTH-1:0]    data_i;
  logic                full_o;
  logic                pop_i;
  logic [WIDTH-1:0]    data_o;
  logic                empty_o;
  logic [DEPTH_AW:0]   level_o;
  logic                overflow_o;
  logic                underflow_o;

  modport master (
    output flush_i, push_i, data_i, pop_i,
    input  full_o, data_o, empty_o, level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, data_i, pop_i,
    output full_o, data_o, empty_o, level_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/ascon_fifo.sv
// First-word-fall-through block FIFO feeding and draining the Ascon core.
// Define ASCON_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module ascon_fifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH_AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ascon_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_AW;
  localparam logic [DEPTH_AW:0] CNT_FULL = {1'b1, {DEPTH_AW{1'b0}}};
  localparam logic [DEPTH_AW:0] CNT_ONE  = {{DEPTH_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_AW-1:0] wr_ptr;
  logic [DEPTH_AW-1:0] rd_ptr;
  logic [DEPTH_AW:0]   count;
  logic                full;
  logic                empty;
  logic                push_acc;
  logic                pop_acc;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A push into a full FIFO is still taken when a pop frees the head slot.
  assign push_acc = bus.push_i & (~full | bus.pop_i) & ~bus.flush_i;
  assign pop_acc  = bus.pop_i & ~empty & ~bus.flush_i;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef ASCON_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push_i & full & ~bus.pop_i) begin
        overflow_q <= 1'b1;
      end
      if (bus.pop_i & empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

  // Stale memory behind an empty FIFO (including right after reset) never leaks out.
  assign bus.data_o  = empty ? '0 : mem[rd_ptr];
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.level_o = count;

endmodule

// File: tb/tb_ascon_fifo.sv
// Directed self-checking bench for ascon_fifo, default depth of 16 words.
// Flag expectations follow whether ASCON_FIFO_ERR_EN is defined for the build.
module tb_ascon_fifo;

  localparam int WIDTH    = 64;
  localparam int DEPTH_AW = 4;
  localparam int DEPTH    = 16;
`ifdef ASCON_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [63:0] model_q [$];

  ascon_fifo_if #(.WIDTH(WIDTH), .DEPTH_AW(DEPTH_AW)) fifo_bus ();

  ascon_fifo #(.WIDTH(WIDTH), .DEPTH_AW(DEPTH_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fifo_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input int i);
    return 64'h1111_0000_0000_0000 | 64'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Holds the inputs across one rising edge, then returns them to idle 1 ns later.
  task automatic applyStimulus(input logic push, input logic pop, input logic flush, input logic [63:0] data);
    fifo_bus.push_i  = push;
    fifo_bus.pop_i   = pop;
    fifo_bus.flush_i = flush;
    fifo_bus.data_i  = data;
    @(posedge clk);
    #1;
    fifo_bus.push_i  = 1'b0;
    fifo_bus.pop_i   = 1'b0;
    fifo_bus.flush_i = 1'b0;
    fifo_bus.data_i  = '0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_empty"}, 64'(fifo_bus.empty_o), 64'd1);
    checkOutput({tag, "_full"},  64'(fifo_bus.full_o),  64'd0);
    checkOutput({tag, "_level"}, 64'(fifo_bus.level_o), 64'd0);
    checkOutput({tag, "_data"},  fifo_bus.data_o,       64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fifo_bus.push_i  = 1'b0;
    fifo_bus.pop_i   = 1'b0;
    fifo_bus.flush_i = 1'b0;
    fifo_bus.data_i  = '0;

    #23;
    checkIdle("reset");
    checkOutput("reset_ovf", 64'(fifo_bus.overflow_o),  64'd0);
    checkOutput("reset_unf", 64'(fifo_bus.underflow_o), 64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three words in, three words out in order.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, word(i));
      if (i == 1) begin
        checkOutput("fwft_data",  fifo_bus.data_o,        word(1));
        checkOutput("fwft_empty", 64'(fifo_bus.empty_o),  64'd0);
      end
    end
    checkOutput("three_level", 64'(fifo_bus.level_o), 64'd3);
    checkOutput("three_head",  fifo_bus.data_o,       word(1));
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      checkOutput("three_pop", fifo_bus.data_o, (i < 3) ? word(i + 1) : 64'd0);
    end
    checkOutput("three_empty", 64'(fifo_bus.empty_o), 64'd1);

    // Seventeen pushes into sixteen slots; the last is dropped.
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, word(i));
      if (i <= DEPTH) model_q.push_back(word(i));
      if (i == 15) checkOutput("fill15_full", 64'(fifo_bus.full_o), 64'd0);
      if (i == 16) checkOutput("fill16_full", 64'(fifo_bus.full_o), 64'd1);
    end
    checkOutput("fill_level", 64'(fifo_bus.level_o),    64'd16);
    checkOutput("fill_full",  64'(fifo_bus.full_o),     64'd1);
    checkOutput("fill_ovf",   64'(fifo_bus.overflow_o), 64'(ERR_EN));
    checkOutput("fill_head",  fifo_bus.data_o,          word(1));

    // Simultaneous push/pop while full, long enough to wrap both pointers twice.
    for (int k = 0; k < 40; k++) begin
      logic [63:0] a;
      a = 64'hA000_0000_0000_0000 | 64'(k);
      applyStimulus(1'b1, 1'b1, 1'b0, a);
      void'(model_q.pop_front());
      model_q.push_back(a);
      checkOutput("pp_full_level", 64'(fifo_bus.level_o), 64'd16);
      checkOutput("pp_full_full",  64'(fifo_bus.full_o),  64'd1);
      checkOutput("pp_full_head",  fifo_bus.data_o,       model_q[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_data", fifo_bus.data_o, model_q[0]);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      void'(model_q.pop_front());
    end
    checkIdle("drained");

    // Flush clears flags; push+pop on empty keeps only the push.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("flush1_ovf", 64'(fifo_bus.overflow_o),  64'd0);
    checkOutput("flush1_unf", 64'(fifo_bus.underflow_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'hBEEF_0000_CAFE_0001);
    checkOutput("ppe_level", 64'(fifo_bus.level_o),     64'd1);
    checkOutput("ppe_empty", 64'(fifo_bus.empty_o),     64'd0);
    checkOutput("ppe_data",  fifo_bus.data_o,           64'hBEEF_0000_CAFE_0001);
    checkOutput("ppe_unf",   64'(fifo_bus.underflow_o), 64'(ERR_EN));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkIdle("flush2");
    checkOutput("flush2_unf", 64'(fifo_bus.underflow_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkIdle("pop_empty");
    checkOutput("pop_empty_unf", 64'(fifo_bus.underflow_o), 64'(ERR_EN));
    checkOutput("pop_empty_ovf", 64'(fifo_bus.overflow_o),  64'd0);

    // Five words resident with overflow set, then flush racing a push.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, word(100 + i));
    checkOutput("ld5_ovf", 64'(fifo_bus.overflow_o), 64'(ERR_EN));
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("ld5_level", 64'(fifo_bus.level_o), 64'd5);
    checkOutput("ld5_head",  fifo_bus.data_o,       word(112));
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hDEAD_0000_0000_00FF);
    checkIdle("flush_push");
    checkOutput("flush_push_ovf", 64'(fifo_bus.overflow_o),  64'd0);
    checkOutput("flush_push_unf", 64'(fifo_bus.underflow_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkIdle("flush_after");

    // Asynchronous reset between edges with seven words stored.
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, word(200 + i));
    checkOutput("pre_rst_level", 64'(fifo_bus.level_o), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("async_rst");
    checkOutput("async_rst_ovf", 64'(fifo_bus.overflow_o),  64'd0);
    checkOutput("async_rst_unf", 64'(fifo_bus.underflow_o), 64'd0);
    #3 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, word(300));
    checkOutput("post_rst_level", 64'(fifo_bus.level_o), 64'd1);
    checkOutput("post_rst_data",  fifo_bus.data_o,       word(300));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkIdle("post_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_fifo.md
# ascon_fifo

Synchronous first-word-fall-through FIFO that buffers 64-bit blocks between the bus-side register interface and the Ascon core. Three instances sit beside the core: AD and PT (bus pushes, core pops) and CT (core pushes, bus pops). The head word is presented combinationally so the core can sample it in the same cycle it asserts pop. A flush input lets the core clear stale data at the start of each operation.

## Interface
Parameters:
- `WIDTH`, 64, data word width in bits.
- `DEPTH_AW`, 4, address width; depth = 2**DEPTH_AW words (default 16 words = 128 bytes).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of contents and pointers.
- `push_i`  in  1  write `data_i` at the tail.
- `data_i`  in  WIDTH  write data.
- `full_o`  out  1  no free entry.
- `pop_i`  in  1  discard the head word.
- `data_o`  out  WIDTH  head word (FWFT); zero when empty.
- `empty_o`  out  1  no stored word.
- `level_o`  out  DEPTH_AW+1  number of stored words, 0..2**DEPTH_AW.
- `overflow_o`  out  1  sticky flag: push attempted while full.
- `underflow_o`  out  1  sticky flag: pop attempted while empty.

## Operation
- Storage: register array of 2**DEPTH_AW words, not reset. Write pointer, read pointer and count are reset to 0.
- Pointers are DEPTH_AW bits wide and wrap modulo depth. Full and empty are derived from the registered count, not from pointer comparison.
- Accepted push: `push_i & (!full_o | pop_i)`. Accepted pop: `pop_i & !empty_o`.
- Push while full without pop: the word is dropped and the FIFO is unchanged.
- Push and pop together while full: both accepted; the head advances, the new word is written into the freed slot, and the count stays at depth.
- Push and pop together while empty: the pop is ignored and the push is accepted; the count becomes 1.
- Pop while empty: ignored; no pointer moves.
- `flush_i` has priority over push and pop. In a flush cycle, pointers and count go to 0, any push in that cycle is dropped, and both sticky flags clear.
- `data_o = empty_o ? '0 : mem[rd_ptr]`, which is a combinational read.
- `level_o` equals the registered count. `empty_o = (count == 0)`; `full_o = (count == 2**DEPTH_AW)`.

## Timing
- Reset values: `empty_o=1`, `full_o=0`, `level_o=0`, `data_o=0`, `overflow_o=0`, `underflow_o=0`.
- Push accepted at edge n: `empty_o` falls and `data_o` shows the word after edge n (latency 1 cycle).
- Pop accepted at edge n: `data_o` shows the next word (or 0 if the FIFO is now empty) after edge n.
- Flush at edge n: `empty_o=1` and `level_o=0` after edge n.
- Asserting `rst_n` low mid-operation clears state immediately, without waiting for a clock edge. Memory contents are unspecified, but `data_o` is masked to 0.
- All outputs are glitch-free functions of registers, except `data_o`, which is a mux of registers.

## Configuration
- `ASCON_FIFO_ERR_EN` defined: `overflow_o` sets on a push with `full_o & !pop_i`, and `underflow_o` sets on a pop with `empty_o`. Both flags hold until flush or reset.
- `ASCON_FIFO_ERR_EN` undefined: both ports are tied to 0 and no flag registers are synthesised. All other behaviour is identical.

## Test plan
- Reset, then push 0x1111_0000_0000_0001, 0x...02, 0x...03 on consecutive cycles -> `level_o`=3, `data_o`=0x...01. Three pops return 01, 02, 03 in order; `empty_o`=1 and `data_o`=0.
- Push 17 words into a depth-16 FIFO -> `full_o`=1 after word 16, `level_o`=16, word 17 is dropped, and `overflow_o`=1 (macro on) or 0 (macro off). Draining returns words 1..16.
- With the FIFO full, push word A and pop together -> `level_o` stays 16 and `full_o` stays 1. Draining yields words 2..16 then A. Repeat 40 cycles to check pointer wrap.
- With the FIFO empty, push and pop together -> `level_o`=1 and the word appears on `data_o`. A pop on an empty FIFO gives `underflow_o`=1 (macro on).
- Load 5 words with `overflow_o` set, then assert `flush_i` together with `push_i` -> next cycle `level_o`=0, `empty_o`=1, flags cleared, and the pushed word is absent.
- Drive `rst_n` low between clock edges while `level_o`=7 -> outputs take their reset values immediately. After release, a single push/pop works normally.
